packed_array_slice_reader: RTL

//   Reader side of the 2D packed-array path: accepts one flattened WA x WB packed word per frame
//   and streams its WB-bit elements out one per handshake, in ascending or descending element order.

---
 rtl/packed_array_pkg.sv | 17 +
 rtl/packed_elem_mux.sv | 28 ++
 rtl/packed_array_slice_reader.sv | 132 +++++++++++++
 3 files changed

// File: rtl/packed_array_pkg.sv
// packed_array_pkg
//   Types and default geometry shared by the packed-array writer and the
//   slice reader. WA is the element count per frame and WB is the bits per
//   element.
package packed_array_pkg;

  localparam int WA_DEF = 8;
  localparam int WB_DEF = 8;

  typedef logic [WB_DEF-1:0] elem_t;

  typedef enum logic {
    ORD_ASC = 1'b0,
    ORD_DSC = 1'b1
  } order_e;

endpackage

// File: rtl/packed_elem_mux.sv
// packed_elem_mux
//   Combinational WA:1 selector. It returns element idx of a flattened
//   WA x WB word, where element i is data[i*WB +: WB]. An index outside
//   [0, WA-1] returns zero.
// Ports
//   data  in   WA*WB  flattened packed word
//   idx   in   IW     element index
//   sel   out  WB     selected element
module packed_elem_mux
  import packed_array_pkg::*;
#(
  parameter int WA = WA_DEF,
  parameter int WB = WB_DEF,
  parameter int IW = (WA > 1) ? $clog2(WA) : 1
) (
  input  logic [WA*WB-1:0] data,
  input  logic [IW-1:0]    idx,
  output logic [WB-1:0]    sel
);

  always_comb begin
    sel = '0;
    for (int i = 0; i < WA; i++) begin
      if (idx == IW'(i)) sel = data[i*WB +: WB];
    end
  end

endmodule

// File: rtl/packed_array_slice_reader.sv
// packed_array_slice_reader
//   Accepts one flattened WA x WB frame per handshake. It then streams the
//   frame's WB-bit elements out, one per output handshake. Elements go out
//   in ascending order (0 first) or descending order (WA-1 first). Frames
//   can follow each other with no bubble.
// Ports
//   clk        in   1      clock
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      frame offered
//   in_ready   out  1      frame accepted when in_valid && in_ready
//   in_data    in   WA*WB  packed frame
//   in_order   in   1      0 ascending, 1 descending element order
//   in_count   in   CW     elements to emit (0 = empty, >WA clamps to WA)
//   out_valid  out  1      element available
//   out_ready  in   1      element consumed when out_valid && out_ready
//   out_data   out  WB     current element
//   out_index  out  IW     index of current element within the frame
//   out_last   out  1      current element is the final one of the frame
//   busy       out  1      frame in progress
//
// state    | meaning
// S_IDLE   | no frame held, in_ready high, out_valid low
// S_STREAM | frame held, out_valid high, emitting remaining elements
module packed_array_slice_reader
  import packed_array_pkg::*;
#(
  parameter int WA = WA_DEF,
  parameter int WB = WB_DEF,
  localparam int CW = $clog2(WA + 1),
  localparam int IW = (WA > 1) ? $clog2(WA) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WA*WB-1:0] in_data,
  input  logic             in_order,
  input  logic [CW-1:0]    in_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WB-1:0]    out_data,
  output logic [IW-1:0]    out_index,
  output logic             out_last,
  output logic             busy
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  logic [0:0]       state;
  logic [WA*WB-1:0] frame_data;
  order_e           frame_order;
  logic [CW-1:0]    remaining;

  logic             accept;
  logic             advance;
  logic [CW-1:0]    clamp_count;
  logic [IW-1:0]    first_idx;
  logic [IW-1:0]    next_idx;
  logic [IW-1:0]    sel_idx;
  logic [WA*WB-1:0] sel_src;
  logic [WB-1:0]    sel_data;

  always_comb begin
    advance     = out_valid && out_ready;
    in_ready    = (state == S_IDLE) || (advance && out_last);
    accept      = in_valid && in_ready;
    busy        = (state == S_STREAM);
    clamp_count = (in_count > CW'(WA)) ? CW'(WA) : in_count;
    first_idx   = (order_e'(in_order) == ORD_DSC) ? IW'(WA - 1) : '0;
    // next_idx is only used when the current element is not the last one.
    // Because of that it never steps outside [0, WA-1].
    next_idx    = (frame_order == ORD_DSC) ? (out_index - IW'(1))
                                           : (out_index + IW'(1));
    // A single mux serves two cases. On accept it selects the first element
    // of the incoming word. Otherwise it selects the next element of the
    // held frame.
    sel_src     = accept ? in_data : frame_data;
    sel_idx     = accept ? first_idx : next_idx;
  end

  packed_elem_mux #(
    .WA (WA),
    .WB (WB),
    .IW (IW)
  ) u_mux (
    .data (sel_src),
    .idx  (sel_idx),
    .sel  (sel_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      frame_data  <= '0;
      frame_order <= ORD_ASC;
      remaining   <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= '0;
      out_index   <= '0;
    end else if (accept) begin
      frame_data  <= in_data;
      frame_order <= order_e'(in_order);
      remaining   <= clamp_count;
      if (clamp_count != '0) begin
        state     <= S_STREAM;
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_index <= first_idx;
        out_last  <= (clamp_count == CW'(1));
      end else begin
        state     <= S_IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end else if (advance) begin
      if (out_last) begin
        state     <= S_IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        remaining <= '0;
      end else begin
        out_data  <= sel_data;
        out_index <= next_idx;
        remaining <= remaining - CW'(1);
        out_last  <= (remaining == CW'(2));
      end
    end
  end

endmodule
